// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: widths, opcodes, field positions,
// FSM encoding and the ID/EX latch payload.
package decode_stage_pkg;

  localparam int unsigned NREGS = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned OPW   = 4;

  // Instruction field positions
  localparam int unsigned OP_LSB = 12;
  localparam int unsigned RD_LSB = 8;
  localparam int unsigned RS_LSB = 4;
  localparam int unsigned RT_LSB = 0;

  // Opcodes
  localparam logic [OPW-1:0] OP_NOP  = 4'h0;
  localparam logic [OPW-1:0] OP_ADD  = 4'h1;
  localparam logic [OPW-1:0] OP_SUB  = 4'h2;
  localparam logic [OPW-1:0] OP_AND  = 4'h3;
  localparam logic [OPW-1:0] OP_OR   = 4'h4;
  localparam logic [OPW-1:0] OP_ADDI = 4'h5;
  localparam logic [OPW-1:0] OP_LW   = 4'h6;
  localparam logic [OPW-1:0] OP_SW   = 4'h7;
  localparam logic [OPW-1:0] OP_BEQ  = 4'h8;
  localparam logic [OPW-1:0] OP_JMP  = 4'h9;
  localparam logic [OPW-1:0] OP_HALT = 4'hF;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  // ID/EX latch contents
  typedef struct packed {
    logic           valid;
    logic [OPW-1:0] opcode;
    logic [AW-1:0]  rd;
    logic [DW-1:0]  a_val;
    logic [DW-1:0]  b_val;
    logic [DW-1:0]  imm;
    logic [DW-1:0]  pc;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           branch;
    logic           jump;
    logic           illegal;
  } idex_t;

  function automatic logic [DW-1:0] sext4(input logic [3:0] v);
    return {{(DW-4){v[3]}}, v};
  endfunction

  function automatic logic [DW-1:0] sext8(input logic [7:0] v);
    return {{(DW-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/decode_stage_register_file.sv
// 16x16 register file: two read ports, one write port, r0 hard-wired to zero,
// same-cycle write-to-read bypass, synchronous clear.
module decode_stage_register_file
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] ra_addr,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] ra_data,
  output logic [DW-1:0] rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NREGS];

  // Storage: clear on reset, otherwise write any register except r0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Read port A with bypass of a same-cycle write
  always_comb begin
    ra_data = '0;
    if (ra_addr != '0) begin
      ra_data = (we && (wa == ra_addr)) ? wd : mem[ra_addr];
    end
  end

  // Read port B with bypass of a same-cycle write
  always_comb begin
    rb_data = '0;
    if (rb_addr != '0) begin
      rb_data = (we && (wa == rb_addr)) ? wd : mem[rb_addr];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, register read, load-use stall, flush,
// RUN/HALTED control and the ID/EX pipeline latch.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] instruction,
  input  logic [DW-1:0] pc_in,
  input  logic          valid_in,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          stall,
  output logic          halted,
  output logic          valid_out,
  output logic [3:0]    opcode_out,
  output logic [3:0]    rd_out,
  output logic [DW-1:0] a_val_out,
  output logic [DW-1:0] b_val_out,
  output logic [DW-1:0] imm_out,
  output logic [DW-1:0] pc_out,
  output logic          reg_write_out,
  output logic          mem_read_out,
  output logic          mem_write_out,
  output logic          branch_out,
  output logic          jump_out,
  output logic          illegal_out
);

  state_e         state;
  idex_t          idex;
  idex_t          dec;
  logic [OPW-1:0] op;
  logic [AW-1:0]  rd;
  logic [AW-1:0]  rs;
  logic [AW-1:0]  rt;
  logic [AW-1:0]  a_addr;
  logic [AW-1:0]  b_addr;
  logic           a_use;
  logic           b_use;
  logic [DW-1:0]  a_rd;
  logic [DW-1:0]  b_rd;
  logic           hazard;
  logic           bubble;

  assign op = instruction[OP_LSB +: OPW];
  assign rd = instruction[RD_LSB +: AW];
  assign rs = instruction[RS_LSB +: AW];
  assign rt = instruction[RT_LSB +: AW];

  decode_stage_register_file u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .ra_addr (a_addr),
    .rb_addr (b_addr),
    .ra_data (a_rd),
    .rb_data (b_rd),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  // Operand routing: which register feeds each port, and whether it is used
  always_comb begin
    a_addr = '0;
    b_addr = '0;
    a_use  = 1'b0;
    b_use  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        a_addr = rs; a_use = 1'b1;
        b_addr = rt; b_use = 1'b1;
      end
      OP_ADDI: begin
        a_addr = rd; a_use = 1'b1;
      end
      OP_LW: begin
        a_addr = rs; a_use = 1'b1;
      end
      OP_SW: begin
        a_addr = rs; a_use = 1'b1;
        b_addr = rd; b_use = 1'b1;
      end
      OP_BEQ: begin
        a_addr = rd; a_use = 1'b1;
        b_addr = rs; b_use = 1'b1;
      end
      default: ;
    endcase
  end

  // Decoded payload for the current instruction
  always_comb begin
    dec        = '0;
    dec.valid  = 1'b1;
    dec.opcode = op;
    dec.rd     = rd;
    dec.pc     = pc_in;
    dec.a_val  = a_use ? a_rd : '0;
    dec.b_val  = b_use ? b_rd : '0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: dec.reg_write = 1'b1;
      OP_ADDI: begin
        dec.reg_write = 1'b1;
        dec.imm       = sext8(instruction[7:0]);
      end
      OP_LW: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
        dec.imm       = sext4(instruction[3:0]);
      end
      OP_SW: begin
        dec.mem_write = 1'b1;
        dec.imm       = sext4(instruction[3:0]);
      end
      OP_BEQ: begin
        dec.branch = 1'b1;
        dec.imm    = sext4(instruction[3:0]);
      end
      OP_JMP: begin
        dec.jump = 1'b1;
        dec.imm  = {pc_in[15:12], instruction[11:0]};
      end
      OP_NOP, OP_HALT: ;
      default: dec.illegal = 1'b1;
    endcase
  end

  // Load-use: the load in ID/EX targets a register this instruction reads
  assign hazard = valid_in && (state == RUN) && idex.valid && idex.mem_read &&
                  (idex.rd != '0) &&
                  ((a_use && (a_addr == idex.rd)) || (b_use && (b_addr == idex.rd)));

  assign stall  = (state == HALTED) || (hazard && !flush);
  assign bubble = (state == HALTED) || flush || !valid_in || hazard;

  // FSM and ID/EX latch
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      idex  <= '0;
    end else begin
      idex <= bubble ? idex_t'('0) : dec;
      if ((state == RUN) && !bubble && (op == OP_HALT)) begin
        state <= HALTED;
      end
    end
  end

  assign halted        = (state == HALTED);
  assign valid_out     = idex.valid;
  assign opcode_out    = idex.opcode;
  assign rd_out        = idex.rd;
  assign a_val_out     = idex.a_val;
  assign b_val_out     = idex.b_val;
  assign imm_out       = idex.imm;
  assign pc_out        = idex.pc;
  assign reg_write_out = idex.reg_write;
  assign mem_read_out  = idex.mem_read;
  assign mem_write_out = idex.mem_write;
  assign branch_out    = idex.branch;
  assign jump_out      = idex.jump;
  assign illegal_out   = idex.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed table, hand sequences and
// randomized traffic against an instruction-level reference model.
`timescale 1ns/1ps
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instruction;
  logic [15:0] pc_in;
  logic        valid_in;
  logic        flush;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall;
  logic        halted;
  logic        valid_out;
  logic [3:0]  opcode_out;
  logic [3:0]  rd_out;
  logic [15:0] a_val_out;
  logic [15:0] b_val_out;
  logic [15:0] imm_out;
  logic [15:0] pc_out;
  logic        reg_write_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic        branch_out;
  logic        jump_out;
  logic        illegal_out;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instruction   (instruction),
    .pc_in         (pc_in),
    .valid_in      (valid_in),
    .flush         (flush),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .stall         (stall),
    .halted        (halted),
    .valid_out     (valid_out),
    .opcode_out    (opcode_out),
    .rd_out        (rd_out),
    .a_val_out     (a_val_out),
    .b_val_out     (b_val_out),
    .imm_out       (imm_out),
    .pc_out        (pc_out),
    .reg_write_out (reg_write_out),
    .mem_read_out  (mem_read_out),
    .mem_write_out (mem_write_out),
    .branch_out    (branch_out),
    .jump_out      (jump_out),
    .illegal_out   (illegal_out)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] pc;
    logic [5:0]  fl;   // reg_write, mem_read, mem_write, branch, jump, illegal
  } out_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] pc;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [5:0]  fl;
  } vec_t;

  out_t act;
  assign act = {valid_out, opcode_out, rd_out, a_val_out, b_val_out, imm_out, pc_out,
                reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out, illegal_out};

  int checks = 0;
  int errors = 0;
  logic last_stall;

  // Reference model state
  logic [15:0] mregs [16];
  out_t        mexp;
  logic        mhalt;

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic logic [15:0] mread(input logic [3:0] r);
    if (r == 4'd0) return 16'h0;
    if (wb_en && (wb_addr == r)) return wb_data;
    return mregs[r];
  endfunction

  function automatic logic [15:0] ext(input int v, input int bits);
    int s;
    s = v;
    if (s >= (1 << (bits - 1))) s = s - (1 << bits);
    return 16'(s);
  endfunction

  // Registers an instruction reads, as a set
  function automatic logic [15:0] src_set(input logic [15:0] ins);
    int o, d, s, t;
    o = int'(ins[15:12]); d = int'(ins[11:8]); s = int'(ins[7:4]); t = int'(ins[3:0]);
    case (o)
      1, 2, 3, 4: return (16'h1 << s) | (16'h1 << t);
      5:          return 16'h1 << d;
      6:          return 16'h1 << s;
      7, 8:       return (16'h1 << s) | (16'h1 << d);
      default:    return 16'h0;
    endcase
  endfunction

  function automatic out_t ref_decode(input logic [15:0] ins, input logic [15:0] pc);
    out_t e;
    int o;
    e = '0;
    o = int'(ins[15:12]);
    e.valid = 1'b1; e.op = ins[15:12]; e.rd = ins[11:8]; e.pc = pc;
    case (o)
      1, 2, 3, 4: begin e.a = mread(ins[7:4]);  e.b = mread(ins[3:0]); e.fl = 6'b100000; end
      5: begin e.a = mread(ins[11:8]); e.imm = ext(int'(ins[7:0]), 8); e.fl = 6'b100000; end
      6: begin e.a = mread(ins[7:4]);  e.imm = ext(int'(ins[3:0]), 4); e.fl = 6'b110000; end
      7: begin e.a = mread(ins[7:4]);  e.b = mread(ins[11:8]);
               e.imm = ext(int'(ins[3:0]), 4); e.fl = 6'b001000; end
      8: begin e.a = mread(ins[11:8]); e.b = mread(ins[7:4]);
               e.imm = ext(int'(ins[3:0]), 4); e.fl = 6'b000100; end
      9: begin e.imm = (pc & 16'hF000) | (ins & 16'h0FFF); e.fl = 6'b000010; end
      0, 15: ;
      default: e.fl = 6'b000001;
    endcase
    return e;
  endfunction

  function automatic logic model_hazard();
    logic [15:0] srcs;
    srcs = src_set(instruction);
    return valid_in && !mhalt && mexp.valid && mexp.fl[4] && (mexp.rd != 4'd0) && srcs[mexp.rd];
  endfunction

  task automatic model_step();
    out_t nx;
    logic hz;
    if (!reset_n) begin
      mexp  = '0;
      mhalt = 1'b0;
      for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
      return;
    end
    hz = model_hazard();
    nx = ref_decode(instruction, pc_in);
    if (mhalt || flush || !valid_in || hz) nx = '0;
    else if (nx.op == 4'hF) mhalt = 1'b1;
    if (wb_en && (wb_addr != 4'd0)) mregs[wb_addr] = wb_data;
    mexp = nx;
  endtask

  // One clock: drive at negedge, check stall before the edge, outputs after
  task automatic cycle(input logic [15:0] ins, input logic [15:0] pc, input logic vin,
                       input logic fl, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic rn);
    @(negedge clk);
    instruction = ins; pc_in = pc; valid_in = vin; flush = fl;
    wb_en = we; wb_addr = wa; wb_data = wd; reset_n = rn;
    #1;
    last_stall = stall;
    chk("stall", 128'(stall), 128'(mhalt || (!flush && model_hazard())));
    @(posedge clk);
    model_step();
    #1;
    chk("outputs", 128'(act), 128'(mexp));
    chk("halted", 128'(halted), 128'(mhalt));
  endtask

  task automatic run(input logic [15:0] ins, input logic [15:0] pc);
    cycle(ins, pc, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
  endtask

  task automatic idle();
    cycle(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
  endtask

  task automatic wb(input logic [3:0] wa, input logic [15:0] wd);
    cycle(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, wa, wd, 1'b1);
  endtask

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{16'h1123, 16'h0100, 4'h1, 16'h2222, 16'h3333, 16'h0000, 6'b100000};
    tbl[1]  = '{16'h2453, 16'h0102, 4'h4, 16'h5555, 16'h3333, 16'h0000, 6'b100000};
    tbl[2]  = '{16'h3612, 16'h0104, 4'h6, 16'h1111, 16'h2222, 16'h0000, 6'b100000};
    tbl[3]  = '{16'h4701, 16'h0106, 4'h7, 16'h0000, 16'h1111, 16'h0000, 6'b100000};
    tbl[4]  = '{16'h5AFF, 16'h0108, 4'hA, 16'hAAAA, 16'h0000, 16'hFFFF, 6'b100000};
    tbl[5]  = '{16'h5305, 16'h010A, 4'h3, 16'h3333, 16'h0000, 16'h0005, 6'b100000};
    tbl[6]  = '{16'h6418, 16'h010C, 4'h4, 16'h1111, 16'h0000, 16'hFFF8, 6'b110000};
    tbl[7]  = '{16'h7237, 16'h010E, 4'h2, 16'h3333, 16'h2222, 16'h0007, 6'b001000};
    tbl[8]  = '{16'h8129, 16'h0110, 4'h1, 16'h1111, 16'h2222, 16'hFFF9, 6'b000100};
    tbl[9]  = '{16'h9123, 16'h5000, 4'h1, 16'h0000, 16'h0000, 16'h5123, 6'b000010};
    tbl[10] = '{16'h0000, 16'h0200, 4'h0, 16'h0000, 16'h0000, 16'h0000, 6'b000000};
    tbl[11] = '{16'hB000, 16'h0202, 4'h0, 16'h0000, 16'h0000, 16'h0000, 6'b000001};
    tbl[12] = '{16'hC5FF, 16'h0204, 4'h5, 16'h0000, 16'h0000, 16'h0000, 6'b000001};

    // Power-up reset (unchecked), then one checked reset cycle
    instruction = 16'h0; pc_in = 16'h0; valid_in = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 4'd0; wb_data = 16'h0; reset_n = 1'b0;
    repeat (2) @(posedge clk);
    model_step();
    cycle(16'h1123, 16'h0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("reset_outputs", 128'(act), 128'(0));

    // Write-back then read through port A
    wb(4'd3, 16'h1234);
    run(16'h1130, 16'h0010);
    chk("add_a", 128'(a_val_out), 128'(16'h1234));
    chk("add_b", 128'(b_val_out), 128'(16'h0000));
    chk("add_rw", 128'(reg_write_out), 128'(1));
    chk("add_rd", 128'(rd_out), 128'(1));

    // Same-cycle bypass, and r0 ignores writes
    cycle(16'h2250, 16'h0012, 1'b1, 1'b0, 1'b1, 4'd5, 16'h00AA, 1'b1);
    chk("bypass_a", 128'(a_val_out), 128'(16'h00AA));
    wb(4'd0, 16'hFFFF);
    run(16'h1200, 16'h0014);
    chk("r0_zero", 128'(a_val_out), 128'(16'h0000));

    // Load-use stall with bubble, then the re-presented ADD
    run(16'h6410, 16'h0020);
    run(16'h1540, 16'h0022);
    chk("lu_stall", 128'(last_stall), 128'(1));
    chk("lu_bubble", 128'(valid_out), 128'(0));
    run(16'h1540, 16'h0022);
    chk("lu_release", 128'(last_stall), 128'(0));
    chk("lu_add_valid", 128'(valid_out), 128'(1));
    chk("lu_add_rd", 128'(rd_out), 128'(5));
    run(16'h6410, 16'h0024);
    run(16'h1506, 16'h0026);
    chk("lu_nodep", 128'(last_stall), 128'(0));
    chk("lu_nodep_valid", 128'(valid_out), 128'(1));

    // Directed decode table
    for (int i = 1; i < 16; i++) wb(4'(i), 16'(i * 16'h1111));
    foreach (tbl[k]) begin
      run(tbl[k].ins, tbl[k].pc);
      chk($sformatf("tbl%0d", k), 128'(act),
          128'({1'b1, tbl[k].ins[15:12], tbl[k].rd, tbl[k].a, tbl[k].b,
                tbl[k].imm, tbl[k].pc, tbl[k].fl}));
      idle();
    end

    // Randomized traffic; a stalled instruction is re-presented
    begin
      logic [15:0] ins, pc;
      logic vin;
      ins = 16'h0; pc = 16'h0; vin = 1'b0;
      for (int n = 0; n < 400; n++) begin
        if (!last_stall) begin
          ins = 16'($urandom);
          ins[15:12] = 4'($urandom_range(0, 14));
          if ($urandom_range(0, 1) == 1) begin
            ins[11:10] = 2'b00;
            ins[7:6]   = 2'b00;
          end
          pc  = 16'($urandom);
          vin = ($urandom_range(0, 7) != 0);
        end
        cycle(ins, pc, vin, ($urandom_range(0, 7) == 0), 1'($urandom),
              4'($urandom), 16'($urandom), 1'b1);
      end
    end

    // Flush kills an ADD and overrides a pending load-use stall
    idle();
    cycle(16'h1123, 16'h0300, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1);
    chk("flush_valid", 128'(valid_out), 128'(0));
    run(16'h6410, 16'h0302);
    cycle(16'h1540, 16'h0304, 1'b1, 1'b1, 1'b0, 4'd0, 16'h0, 1'b1);
    chk("flush_hz_stall", 128'(last_stall), 128'(0));
    chk("flush_hz_valid", 128'(valid_out), 128'(0));
    chk("flush_hz_flags", 128'(act.fl), 128'(0));

    // HALT latched once, then halted with permanent stall
    run(16'hF000, 16'h0400);
    chk("halt_valid", 128'(valid_out), 128'(1));
    chk("halt_op", 128'(opcode_out), 128'(4'hF));
    chk("halted_set", 128'(halted), 128'(1));
    run(16'h1123, 16'h0402);
    chk("halt_stall", 128'(last_stall), 128'(1));
    chk("halt_bubble", 128'(valid_out), 128'(0));
    cycle(16'h1123, 16'h0402, 1'b1, 1'b1, 1'b1, 4'd9, 16'hBEEF, 1'b1);
    chk("halt_flush_stall", 128'(last_stall), 128'(1));
    repeat (3) run(16'h1123, 16'h0402);
    chk("halt_sticky", 128'(halted), 128'(1));

    // Reset leaves HALTED and clears the register file
    cycle(16'h1123, 16'h0500, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
    chk("rst_outputs", 128'(act), 128'(0));
    chk("rst_halted", 128'(halted), 128'(0));
    run(16'h1123, 16'h0502);
    chk("rst_run_valid", 128'(valid_out), 128'(1));
    chk("rst_regs_clear", 128'(a_val_out), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage; consumes the fetch latch outputs (instruction, Next_PC).
- Decodes the 16-bit instruction and reads a 16x16 register file with write-back port and write-through bypass.
- Detects load-use hazards and stalls fetch; applies branch flush; latches results into the ID/EX latch.
- Holds a RUN/HALTED state machine.

Parameters:
- NREGS, 16, register count (address width 4).
- DW, 16, datapath and instruction width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- instruction  in  16  from fetch latch
- pc_in  in  16  Next_PC from fetch latch
- valid_in  in  1  fetch latch holds a real instruction
- flush  in  1  taken branch/jump resolved downstream; kill current decode
- wb_en  in  1  register write-back enable
- wb_addr  in  4  write-back register
- wb_data  in  16  write-back data
- stall  out  1  fetch must hold PC and fetch latch
- halted  out  1  FSM in HALTED
- valid_out  out  1  ID/EX latch holds a real instruction
- opcode_out  out  4  latched opcode
- rd_out  out  4  destination register
- a_val_out  out  16  port A operand
- b_val_out  out  16  port B operand
- imm_out  out  16  extended immediate / jump target
- pc_out  out  16  latched pc_in
- reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out, illegal_out  out  1 each  control flags

Behaviour:
- Fields: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: R-type, A=rs, B=rt, reg_write.
  - 5 ADDI: A=rd, imm=sext([7:0]), reg_write.
  - 6 LW: A=rs, imm=sext([3:0]), mem_read, reg_write.
  - 7 SW: A=rs, B=rd, imm=sext([3:0]), mem_write.
  - 8 BEQ: A=rd, B=rs, imm=sext([3:0]), branch.
  - 9 JMP: imm={pc_in[15:12],[11:0]}, jump.
  - F HALT.
  - A–E: illegal_out=1, all other flags 0, no reg_write.
- Unused operand ports output 0; imm_out=0 where unused.
- Register file: r0 reads 0 and ignores writes. Write on clk when wb_en. Same-cycle read of wb_addr (≠0) returns wb_data (bypass). Reset clears all registers.
- Latency: one cycle. Instruction accepted at edge N appears on the *_out signals after edge N.
- Load-use hazard: stall=1 (combinational) when all of the following hold:
  - valid_in and state RUN;
  - valid_out, mem_read_out, rd_out≠0;
  - rd_out equals a source register the current opcode actually uses.
- On a hazard edge: insert a bubble (valid_out=0, all flags 0); the instruction is re-presented next cycle.
- Flush (priority over stall and hazard): next valid_out=0, all flags 0; stall forced 0 that cycle; FSM unaffected.
- valid_in=0: bubble latched.
- FSM:
  - RUN→HALTED when a valid, non-flushed, non-stalled HALT is latched (valid_out=1, opcode F for one cycle).
  - In HALTED: stall=1, halted=1, bubbles latched every cycle, flush ignored.
  - Exit only by reset.
- Reset (reset_n=0 at edge): all outputs 0, state RUN, stall=0. Reset mid-stall or mid-halt wins unconditionally.
- wb writes proceed during stall, flush and HALTED.

Decomposition:
- Shared package: opcode constants (OP_NOP … OP_HALT), field bit positions, FSM state encoding (RUN=0, HALTED=1).
- Sub-module register_file: 2 read ports, 1 write port, r0 zero, bypass, synchronous clear.
- Decode logic, hazard check, FSM and ID/EX latch stay in decode_stage.

Test Plan:
- Reset then write r3=0x1234 via wb; decode 0x1130 (ADD r1,r3,r0) → next cycle a_val_out=0x1234, b_val_out=0, reg_write_out=1, rd_out=1.
- Same cycle wb r5=0x00AA and decode 0x2250 (SUB r2,r5,r0) → a_val_out=0x00AA (bypass); write to r0 → r0 still reads 0.
- Decode 0x6410 (LW r4,r1,0), then 0x1540 (ADD r5,r4,r0) → stall=1 one cycle, bubble valid_out=0, ADD latched the following cycle; ADD r5,r0,r6 after LW r4 → no stall.
- Decode 0x5AFF (ADDI rA,-1) → imm_out=0xFFFF. 0x9123 with pc_in=0x5000 → imm_out=0x5123, jump_out=1.
- Flush=1 during an ADD, including a simultaneous load-use hazard → valid_out=0, stall=0.
- Decode 0xF000 → one latched HALT, then halted=1, stall=1 indefinitely; 0xB000 → illegal_out=1, reg_write_out=0; reset_n=0 → all outputs 0, RUN.
